// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: one outstanding bus transaction, registered bus outputs,
// byte-lane steering for stores and sign/zero extension for loads.
module rv32i_lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_valid,
  input  logic        lsu_we,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_unsigned,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_value,
  output logic        lsu_stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        lsu_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        unsigned_q;
  logic [7:0]  cnt;

  logic        aligned;
  logic        timeout;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;

  always_comb begin
    aligned    = 1'b0;
    be_next    = 4'b1111;
    wdata_next = rs2_value;
    case (lsu_size)
      2'b00: begin
        aligned    = 1'b1;
        be_next    = 4'b0001 << alu_result[1:0];
        wdata_next = {4{rs2_value[7:0]}};
      end
      2'b01: begin
        aligned    = ~alu_result[0];
        be_next    = 4'b0011 << alu_result[1:0];
        wdata_next = {2{rs2_value[15:0]}};
      end
      2'b10: aligned = (alu_result[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // >= rather than == so a grant on the last budget cycle still leaves WAIT bounded
  assign timeout = (state != IDLE) && (cnt >= TO_LAST);

  assign rd_shift = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    rd_ext = rd_shift;
    case (size_q)
      2'b00:   rd_ext = unsigned_q ? {24'd0, rd_shift[7:0]}  : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   rd_ext = unsigned_q ? {16'd0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Completion always takes priority over a coincident timeout
  always_comb begin
    state_next = state;
    lsu_stall  = 1'b0;
    case (state)
      IDLE: begin
        lsu_stall = lsu_valid && aligned;
        if (lsu_valid && aligned) state_next = REQ;
      end
      REQ: begin
        lsu_stall = mem_gnt || !timeout;
        if (mem_gnt)      state_next = WAIT;
        else if (timeout) state_next = IDLE;
      end
      WAIT: begin
        lsu_stall = !mem_rvalid && !timeout;
        if (mem_rvalid || timeout) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_be     <= 4'd0;
      mem_wdata  <= 32'd0;
      load_valid <= 1'b0;
      load_data  <= 32'd0;
      lsu_error  <= 1'b0;
      size_q     <= 2'd0;
      off_q      <= 2'd0;
      unsigned_q <= 1'b0;
      cnt        <= 8'd0;
    end else begin
      load_valid <= 1'b0;
      lsu_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (lsu_valid && aligned) begin
            mem_req    <= 1'b1;
            mem_we     <= lsu_we;
            mem_addr   <= {alu_result[31:2], 2'b00};
            mem_be     <= be_next;
            mem_wdata  <= wdata_next;
            size_q     <= lsu_size;
            off_q      <= alu_result[1:0];
            unsigned_q <= lsu_unsigned;
            cnt        <= 8'd0;
          end else if (lsu_valid) begin
            lsu_error <= 1'b1;
          end
        end
        REQ: begin
          cnt <= cnt + 8'd1;
          if (mem_gnt) begin
            mem_req <= 1'b0;
          end else if (timeout) begin
            mem_req   <= 1'b0;
            lsu_error <= 1'b1;
          end
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
          if (mem_rvalid) begin
            if (!mem_we) begin
              load_valid <= 1'b1;
              load_data  <= rd_ext;
            end
          end else if (timeout) begin
            lsu_error <= 1'b1;
          end
        end
        default: mem_req <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed self-checking bench for rv32i_lsu: stores, loads, misalignment,
// timeout, completion-vs-timeout, back-to-back accept and reset mid-transaction.
module tb_rv32i_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        lsu_valid, lsu_we, lsu_unsigned;
  logic [1:0]  lsu_size;
  logic [31:0] alu_result, rs2_value;
  logic        lsu_stall, load_valid, lsu_error;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int passed = 0;
  int stall_cycles;
  int req_cycles;
  int release_at;
  int err_at;

  always #5 clk = ~clk;

  rv32i_lsu #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .lsu_valid(lsu_valid), .lsu_we(lsu_we), .lsu_size(lsu_size),
    .lsu_unsigned(lsu_unsigned), .alu_result(alu_result), .rs2_value(rs2_value),
    .lsu_stall(lsu_stall), .load_data(load_data), .load_valid(load_valid),
    .lsu_error(lsu_error), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic valid, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] data);
    lsu_valid    = valid;
    lsu_we       = we;
    lsu_size     = size;
    lsu_unsigned = uns;
    alu_result   = addr;
    rs2_value    = data;
  endtask

  // Advance one clock; inputs change and outputs are sampled around the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_be", 32'(mem_be), 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_load_valid", 32'(load_valid), 32'd0);
    checkOutput("rst_load_data", load_data, 32'd0);
    checkOutput("rst_lsu_error", 32'(lsu_error), 32'd0);
    checkOutput("rst_stall", 32'(lsu_stall), 32'd0);

    // SW 0x100, grant in cycle 2, response in cycle 4
    tick();
    stall_cycles = 0;
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
    #1; if (lsu_stall) stall_cycles++;
    tick(); #1;
    if (lsu_stall) stall_cycles++;
    checkOutput("sw_mem_req", 32'(mem_req), 32'd1);
    checkOutput("sw_mem_we", 32'(mem_we), 32'd1);
    checkOutput("sw_mem_addr", mem_addr, 32'h100);
    checkOutput("sw_mem_be", 32'(mem_be), 32'hF);
    checkOutput("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick(); mem_gnt = 1'b1; #1;
    if (lsu_stall) stall_cycles++;
    tick(); mem_gnt = 1'b0; #1;
    if (lsu_stall) stall_cycles++;
    checkOutput("sw_req_drop", 32'(mem_req), 32'd0);
    tick(); mem_rvalid = 1'b1; #1;
    if (lsu_stall) stall_cycles++;
    checkOutput("sw_stall_cycles", 32'(stall_cycles), 32'd4);
    tick(); mem_rvalid = 1'b0; lsu_valid = 1'b0; #1;
    checkOutput("sw_no_load_valid", 32'(load_valid), 32'd0);
    checkOutput("sw_idle_stall", 32'(lsu_stall), 32'd0);

    // LB 0x203, immediate grant, response next cycle
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h203, 32'd0);
    #1; checkOutput("lb_accept_stall", 32'(lsu_stall), 32'd1);
    tick(); mem_gnt = 1'b1; #1;
    checkOutput("lb_mem_be", 32'(mem_be), 32'h8);
    checkOutput("lb_mem_addr", mem_addr, 32'h200);
    checkOutput("lb_mem_we", 32'(mem_we), 32'd0);
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80FFFF7F; #1;
    checkOutput("lb_wait_release", 32'(lsu_stall), 32'd0);
    // Back-to-back LBU presented on the cycle the LB returns to IDLE
    tick(); mem_rvalid = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 32'h203, 32'd0);
    #1;
    checkOutput("lb_load_valid", 32'(load_valid), 32'd1);
    checkOutput("lb_load_data", load_data, 32'hFFFFFF80);
    checkOutput("b2b_accept_stall", 32'(lsu_stall), 32'd1);
    tick(); mem_rvalid = 1'b1; #1;
    checkOutput("lbu_mem_req", 32'(mem_req), 32'd1);
    checkOutput("lbu_load_valid_pulse", 32'(load_valid), 32'd0);
    tick(); mem_rvalid = 1'b0; mem_gnt = 1'b1; #1;
    checkOutput("lbu_rvalid_in_req_ignored", 32'(mem_req), 32'd1);
    checkOutput("lbu_no_early_load", 32'(load_valid), 32'd0);
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; #1;
    tick(); mem_rvalid = 1'b0; lsu_valid = 1'b0; #1;
    checkOutput("lbu_load_valid", 32'(load_valid), 32'd1);
    checkOutput("lbu_load_data", load_data, 32'h00000080);

    // LH 0x101 misaligned
    tick();
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h101, 32'd0);
    #1; checkOutput("lh_mis_stall", 32'(lsu_stall), 32'd0);
    tick(); lsu_valid = 1'b0; #1;
    checkOutput("lh_mis_error", 32'(lsu_error), 32'd1);
    checkOutput("lh_mis_no_req", 32'(mem_req), 32'd0);
    tick(); #1;
    checkOutput("lh_mis_error_pulse", 32'(lsu_error), 32'd0);
    checkOutput("lh_mis_still_no_req", 32'(mem_req), 32'd0);

    // Reserved size on an otherwise aligned address
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 32'h100, 32'd0);
    #1; checkOutput("rsv_stall", 32'(lsu_stall), 32'd0);
    tick(); lsu_valid = 1'b0; #1;
    checkOutput("rsv_error", 32'(lsu_error), 32'd1);
    checkOutput("rsv_no_req", 32'(mem_req), 32'd0);

    // SH 0x102, grant held off for three cycles
    tick();
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 32'h102, 32'h1234ABCD);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      checkOutput("sh_req_held", 32'(mem_req), 32'd1);
      checkOutput("sh_mem_be", 32'(mem_be), 32'hC);
      checkOutput("sh_mem_wdata", mem_wdata, 32'hABCDABCD);
      checkOutput("sh_mem_addr", mem_addr, 32'h100);
    end
    tick(); mem_gnt = 1'b1; #1;
    checkOutput("sh_gnt_payload", mem_wdata, 32'hABCDABCD);
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; #1;
    tick(); mem_rvalid = 1'b0; lsu_valid = 1'b0; #1;
    checkOutput("sh_no_load_valid", 32'(load_valid), 32'd0);
    checkOutput("sh_no_error", 32'(lsu_error), 32'd0);

    // LW 0x300 with no grant: timeout after 16 request cycles
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'd0);
    req_cycles = 0; release_at = -1; err_at = -1;
    for (int i = 0; i < 40; i++) begin
      tick(); #1;
      if (mem_req) req_cycles++;
      if (lsu_error) begin
        err_at = i;
        break;
      end
      if (!lsu_stall && release_at < 0) begin
        release_at = i;
        lsu_valid = 1'b0;
      end
    end
    checkOutput("to_req_cycles", 32'(req_cycles), 32'd16);
    checkOutput("to_release_cycle", 32'(release_at), 32'd15);
    checkOutput("to_error_cycle", 32'(err_at), 32'd16);
    checkOutput("to_req_dropped", 32'(mem_req), 32'd0);
    lsu_valid = 1'b0;

    // Grant on the final budget cycle and response on the next: completion wins
    tick();
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h304, 32'd0);
    for (int i = 0; i < 15; i++) tick();
    tick(); mem_gnt = 1'b1; #1;
    checkOutput("late_gnt_stall", 32'(lsu_stall), 32'd1);
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D; #1;
    checkOutput("late_gnt_no_error", 32'(lsu_error), 32'd0);
    tick(); mem_rvalid = 1'b0; lsu_valid = 1'b0; #1;
    checkOutput("late_rvalid_load_valid", 32'(load_valid), 32'd1);
    checkOutput("late_rvalid_data", load_data, 32'hCAFEF00D);
    checkOutput("late_rvalid_no_error", 32'(lsu_error), 32'd0);

    // Reset during WAIT, then a stray response
    tick();
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'd0);
    tick(); mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0; reset = 1'b1; lsu_valid = 1'b0;
    tick(); reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11223344; #1;
    checkOutput("wrst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("wrst_mem_addr", mem_addr, 32'd0);
    checkOutput("wrst_mem_be", 32'(mem_be), 32'd0);
    checkOutput("wrst_load_data", load_data, 32'd0);
    checkOutput("wrst_stall", 32'(lsu_stall), 32'd0);
    tick(); mem_rvalid = 1'b0; #1;
    checkOutput("wrst_no_load_valid", 32'(load_valid), 32'd0);
    checkOutput("wrst_load_data_held", load_data, 32'd0);
    checkOutput("wrst_no_error", 32'(lsu_error), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
